// File: rtl/div_seq_ctrl_if.sv
// Request/result bundle between the decode stage and the divide sequencer.
// The decode side drives the operands and start; the sequencer returns
// status and the HI/LO results.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] y_hi;
    logic [WIDTH-1:0] y_lo;

    modport master (
        output start, is_signed, S, T,
        input  busy, done, div_by_zero, y_hi, y_lo
    );

    modport slave (
        input  start, is_signed, S, T,
        output busy, done, div_by_zero, y_hi, y_lo
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multi-cycle integer divide sequencer (DIV / DIVU).
// Restoring shift/subtract on operand magnitudes, one quotient bit per cycle,
// followed by a sign fix-up. Quotient lands on y_lo, remainder on y_hi.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    div_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Operands captured with start; the live bus inputs are never used later.
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_t;
    logic             r_sgn_op;

    // Working registers of the shift/subtract loop.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [CW-1:0]    r_cnt;

    // Result registers; they hold the last result while idle.
    logic [WIDTH-1:0] r_y_hi;
    logic [WIDTH-1:0] r_y_lo;
    logic             r_dbz;

    logic [WIDTH-1:0] w_s_mag;
    logic [WIDTH-1:0] w_t_mag;
    logic             w_t_zero;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_last;
    logic             w_busy;
    logic             w_done;

    // Magnitudes only when signed; -0x80..0 stays 0x80..0 as an unsigned magnitude.
    assign w_s_mag  = (r_sgn_op && r_s[WIDTH-1]) ? (-r_s) : r_s;
    assign w_t_mag  = (r_sgn_op && r_t[WIDTH-1]) ? (-r_t) : r_t;
    assign w_t_zero = (r_t == '0);

    // Shifted remainder keeps the bit that falls out of rem, so the trial
    // subtract is exact even for divisors above 2^(WIDTH-1).
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_next = ST_PREP;
                end
            end
            ST_PREP: begin
                w_state_next = w_t_zero ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
                if (w_last) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, divide loop and result writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s      <= '0;
            r_t      <= '0;
            r_sgn_op <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
            r_y_hi   <= '0;
            r_y_lo   <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_s      <= bus.S;
                        r_t      <= bus.T;
                        r_sgn_op <= bus.is_signed;
                        r_dbz    <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_sign_q <= r_sgn_op & (r_s[WIDTH-1] ^ r_t[WIDTH-1]);
                    r_sign_r <= r_sgn_op & r_s[WIDTH-1];
                    r_rem    <= '0;
                    r_quo    <= w_s_mag;
                    r_div    <= w_t_mag;
                    r_cnt    <= '0;
                    if (w_t_zero) begin
                        r_y_lo <= '1;
                        r_y_hi <= r_s;
                        r_dbz  <= 1'b1;
                    end
                end
                ST_ITER: begin
                    if (!w_diff[WIDTH]) begin
                        r_rem <= w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_FIX: begin
                    r_y_lo <= r_sign_q ? (-r_quo) : r_quo;
                    r_y_hi <= r_sign_r ? (-r_rem) : r_rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.div_by_zero = w_done & r_dbz;
    assign bus.y_hi        = r_y_hi;
    assign bus.y_lo        = r_y_lo;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed scenarios plus randomized operations,
// checked every cycle against a transaction-level reference model.
module tb_div_seq_ctrl;
    localparam int W = 32;
    localparam int LAT_NORM = W + 3;
    localparam int LAT_DBZ = 2;

    logic clk;
    logic reset;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference divide from plain arithmetic.
    function automatic void ref_div(input logic [W-1:0] s, input logic [W-1:0] t,
                                    input logic sg, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic dbz);
        longint ls;
        longint lt;
        longint lq;
        longint lr;
        if (t == '0) begin
            q   = '1;
            r   = s;
            dbz = 1'b1;
        end else if (sg) begin
            ls  = longint'($signed(s));
            lt  = longint'($signed(t));
            lq  = ls / lt;
            lr  = ls % lt;
            q   = lq[W-1:0];
            r   = lr[W-1:0];
            dbz = 1'b0;
        end else begin
            q   = s / t;
            r   = s % t;
            dbz = 1'b0;
        end
    endfunction

    // Transaction model: an accepted request makes the unit busy for a fixed
    // number of cycles, the last of which carries done and the new results.
    logic         m_valid = 1'b0;
    logic         m_active = 1'b0;
    int           m_t = 0;
    int           m_len = 0;
    logic [W-1:0] m_yhi = '0;
    logic [W-1:0] m_ylo = '0;
    logic [W-1:0] p_q = '0;
    logic [W-1:0] p_r = '0;
    logic         p_dbz = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_yhi    = '0;
            m_ylo    = '0;
            p_dbz    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_active) begin
            m_t = m_t + 1;
            if (m_t == m_len) begin
                m_yhi = p_r;
                m_ylo = p_q;
            end
            if (m_t > m_len) begin
                m_active = 1'b0;
            end
        end else if (bus.start) begin
            ref_div(bus.S, bus.T, bus.is_signed, p_q, p_r, p_dbz);
            m_active = 1'b1;
            m_t      = 1;
            m_len    = p_dbz ? LAT_DBZ : LAT_NORM;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            logic e_done;
            e_done = m_active && (m_t == m_len);
            chk("busy", 64'(bus.busy), 64'(m_active));
            chk("done", 64'(bus.done), 64'(e_done));
            chk("div_by_zero", 64'(bus.div_by_zero), 64'(e_done && p_dbz));
            chk("y_hi", 64'(bus.y_hi), 64'(m_yhi));
            chk("y_lo", 64'(bus.y_lo), 64'(m_ylo));
        end
    end

    // Issue one request and return in the done cycle (cyc = done cycle index,
    // edge 0 being the accepting edge). A start pulse with S=5,T=1 is injected
    // in cycle inj_cyc if that cycle comes before done.
    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] t, input logic sg,
                          input int inj_cyc, output int cyc);
        @(negedge clk);
        bus.S         = s;
        bus.T         = t;
        bus.is_signed = sg;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.S     = $urandom;
        bus.T     = $urandom;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            if (cyc == inj_cyc) begin
                bus.start = 1'b1;
                bus.S     = 32'd5;
                bus.T     = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        $display("op S=0x%08h T=0x%08h signed=%0d -> done cycle %0d y_lo=0x%08h y_hi=0x%08h dbz=%0d",
                 s, t, sg, cyc, bus.y_lo, bus.y_hi, bus.div_by_zero);
    endtask

    task automatic expect_op(input string name, input int cyc, input int exp_cyc,
                             input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                             input logic exp_dbz);
        chk({name, "_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({name, "_y_lo"}, 64'(bus.y_lo), 64'(exp_lo));
        chk({name, "_y_hi"}, 64'(bus.y_hi), 64'(exp_hi));
        chk({name, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dcount;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] s;
        logic [W-1:0] t;
        logic sg;
        logic dbz;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.S         = '0;
        bus.T         = '0;

        // Pin the reference model to hand-computed values.
        ref_div(32'd100, 32'd7, 1'b0, q, r, dbz);
        chk("model_divu_q", 64'(q), 64'd14);
        chk("model_divu_r", 64'(r), 64'd2);
        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dbz);
        chk("model_div_q", 64'(q), 64'hFFFF_FFFD);
        chk("model_div_r", 64'(r), 64'hFFFF_FFFF);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dbz);
        chk("model_ovf_q", 64'(q), 64'h8000_0000);
        chk("model_ovf_r", 64'(r), 64'd0);
        ref_div(32'h1234_5678, 32'd0, 1'b0, q, r, dbz);
        chk("model_dbz", 64'(dbz), 64'd1);

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_y_lo", 64'(bus.y_lo), 64'd0);
        chk("reset_y_hi", 64'(bus.y_hi), 64'd0);
        reset = 1'b0;

        // Directed cases with literal expectations.
        run_op(32'd100, 32'd7, 1'b0, 0, cyc);
        expect_op("divu_basic", cyc, 35, 32'd14, 32'd2, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, cyc);
        expect_op("div_neg_dividend", cyc, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, cyc);
        expect_op("div_neg_divisor", cyc, 35, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 0, cyc);
        expect_op("div_by_zero", cyc, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, cyc);
        expect_op("div_overflow", cyc, 35, 32'h8000_0000, 32'd0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, cyc);
        expect_op("divu_overflow_ops", cyc, 35, 32'd0, 32'h8000_0000, 1'b0);

        // Start while busy is ignored; start right after DONE is accepted.
        run_op(32'd100, 32'd7, 1'b0, 10, cyc);
        expect_op("busy_protect", cyc, 35, 32'd14, 32'd2, 1'b0);
        run_op(32'd5, 32'd1, 1'b0, 0, cyc);
        expect_op("back_to_back", cyc, 35, 32'd5, 32'd0, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.S         = 32'd100;
        bus.T         = 32'd7;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_y_lo", 64'(bus.y_lo), 64'd0);
        chk("abort_y_hi", 64'(bus.y_hi), 64'd0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        $display("reset mid-op: done pulses after abort = %0d", dcount);
        run_op(32'd100, 32'd7, 1'b0, 0, cyc);
        expect_op("after_abort", cyc, 35, 32'd14, 32'd2, 1'b0);

        // Randomized operations, with stray starts while busy and in DONE.
        for (int i = 0; i < 60; i++) begin
            int sel;
            int inj;
            s   = $urandom;
            t   = $urandom;
            sg  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            case (sel)
                0: t = '0;
                1: t = 32'($urandom_range(1, 20));
                2: t = '1;
                3: s = 32'h8000_0000;
                4: t = 32'h8000_0000;
                default: ;
            endcase
            inj = $urandom_range(0, 40);
            run_op(s, t, sg, inj, cyc);
            ref_div(s, t, sg, q, r, dbz);
            expect_op("random", cyc, (t == '0) ? LAT_DBZ : LAT_NORM, q, r, dbz);
            if ($urandom_range(0, 1) == 1) begin
                bus.start = 1'b1;
                bus.S     = $urandom;
                bus.T     = $urandom;
            end
        end

        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
